// File: rtl/midi_pkg.sv
// midi_pkg
// Shared constants and types for the MIDI note receiver.
//   NOTE_OFF / NOTE_ON : upper nibble of the channel voice status bytes we decode
//   SYS_MIN / RT_MIN   : lower bounds of the system-common and realtime byte ranges
//   uart_state_t       : serial receiver FSM states
//   run_status_t       : parser running-status
//   vel_to_amp()       : 7-bit velocity to 10-bit synth amplitude
package midi_pkg;

    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [7:0] SYS_MIN  = 8'hF0;
    localparam logic [7:0] RT_MIN   = 8'hF8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    typedef enum logic [1:0] {
        NONE,
        OFF,
        ON,
        IGNORE
    } run_status_t;

    // Replicating the top velocity bits into the new LSBs maps 127 to full
    // scale (1023) while keeping 1 -> 8 and 64 -> 516.
    function automatic logic [9:0] vel_to_amp(input logic [6:0] vel);
        return {vel, vel[6:4]};
    endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// midi_uart_rx
// 8N1 serial byte receiver for the MIDI line.
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   midi_in    : raw serial line, idle high, asynchronous to clk
//   rx_byte    : last received byte, valid while byte_valid is high
//   byte_valid : one-cycle pulse when a byte with a good stop bit arrives
//   frame_err  : one-cycle pulse when the stop bit is sampled low
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int CLKSPEED = 48_000_000,
    parameter int BAUD     = 31250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       midi_in,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int DIV = CLKSPEED / BAUD;
    localparam int CW  = $clog2(DIV);
    // The timer counts down to zero, so loads are one less than the interval.
    localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);

    logic        midi_p0;
    logic        midi_p1;
    logic        midi_p2;
    uart_state_t state;
    logic [CW-1:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        cnt_end;

    assign cnt_end = (cnt == '0);

    // Stage p0/p1: two-flop synchroniser; p2 holds the previous synchronised
    // level for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            midi_p0    <= 1'b1;
            midi_p1    <= 1'b1;
            midi_p2    <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            midi_p0    <= midi_in;
            midi_p1    <= midi_p0;
            midi_p2    <= midi_p1;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;

            case (state)
                IDLE: begin
                    if (midi_p2 && !midi_p1) begin
                        state <= START;
                        cnt   <= HALF_LOAD;
                    end
                end
                START: begin
                    if (cnt_end) begin
                        // A line that is high again at mid start bit was a glitch.
                        if (midi_p1) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            cnt     <= FULL_LOAD;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_end) begin
                        cnt     <= FULL_LOAD;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                STOP: begin
                    if (cnt_end) begin
                        // Back to IDLE right at the sample point so a start bit
                        // immediately after the stop bit is not missed.
                        state <= IDLE;
                        if (midi_p1) begin
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data path: LSB-first shift register and byte output, no reset needed
    // because byte_valid qualifies them.
    always_ff @(posedge clk) begin
        if (state == DATA && cnt_end) begin
            shift <= {midi_p1, shift[7:1]};
        end
        if (state == STOP && cnt_end && midi_p1) begin
            rx_byte <= shift;
        end
    end

endmodule

// File: rtl/midi_note_rx.sv
// midi_note_rx
// MIDI Note-On/Note-Off decoder driving a single synth voice with
// last-note priority and running status.
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   midi_in   : raw MIDI serial line, idle high
//   gate      : high while a note is held
//   note      : current MIDI note number
//   amp       : velocity-derived amplitude
//   retrig    : one-cycle pulse on every accepted Note-On
//   frame_err : one-cycle pulse when a stop bit is sampled low
module midi_note_rx
    import midi_pkg::*;
#(
    parameter int CLKSPEED = 48_000_000,
    parameter int BAUD     = 31250,
    parameter int CHANNEL  = 0,
    parameter bit OMNI     = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       midi_in,
    output logic       gate,
    output logic [6:0] note,
    output logic [9:0] amp,
    output logic       retrig,
    output logic       frame_err
);

    localparam logic [3:0] CHAN = 4'(CHANNEL);

    logic [7:0]  rx_byte;
    logic        byte_valid;
    run_status_t run_st;
    logic        want_vel;
    logic [6:0]  key_p0;
    logic        chan_ok;
    logic        voice_st;
    logic        is_data;

    midi_uart_rx #(
        .CLKSPEED (CLKSPEED),
        .BAUD     (BAUD)
    ) u_uart (
        .clk        (clk),
        .rst        (rst),
        .midi_in    (midi_in),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    assign chan_ok  = OMNI || (rx_byte[3:0] == CHAN);
    assign voice_st = (run_st == ON) || (run_st == OFF);
    assign is_data  = !rx_byte[7];

    // Stage p0: the key byte is held until its velocity arrives.
    always_ff @(posedge clk) begin
        if (byte_valid && is_data && voice_st && !want_vel) begin
            key_p0 <= rx_byte[6:0];
        end
    end

    // Stage p1: parser state and registered voice outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_st   <= NONE;
            want_vel <= 1'b0;
            gate     <= 1'b0;
            note     <= '0;
            amp      <= '0;
            retrig   <= 1'b0;
        end else begin
            retrig <= 1'b0;
            if (byte_valid) begin
                if (rx_byte >= RT_MIN) begin
                    // Realtime bytes may land anywhere and leave parsing untouched.
                    run_st <= run_st;
                end else if (rx_byte >= SYS_MIN) begin
                    run_st   <= NONE;
                    want_vel <= 1'b0;
                end else if (!is_data) begin
                    want_vel <= 1'b0;
                    if (chan_ok && rx_byte[7:4] == NOTE_ON) begin
                        run_st <= ON;
                    end else if (chan_ok && rx_byte[7:4] == NOTE_OFF) begin
                        run_st <= OFF;
                    end else begin
                        run_st <= IGNORE;
                    end
                end else if (voice_st) begin
                    if (!want_vel) begin
                        want_vel <= 1'b1;
                    end else begin
                        want_vel <= 1'b0;
                        if (run_st == ON && rx_byte[6:0] != 7'd0) begin
                            note   <= key_p0;
                            amp    <= vel_to_amp(rx_byte[6:0]);
                            gate   <= 1'b1;
                            retrig <= 1'b1;
                        end else if (gate && key_p0 == note) begin
                            // Only the sounding note can release the voice.
                            gate <= 1'b0;
                            amp  <= '0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_note_rx.sv
module tb_midi_note_rx;

    localparam int CLKSPEED = 500_000;
    localparam int BAUD     = 31250;
    localparam int DIV      = CLKSPEED / BAUD;
    localparam int CHAN     = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       midi_in = 1'b1;
    logic       gate_a, gate_b, retrig_a, retrig_b, fe_a, fe_b;
    logic [6:0] note_a, note_b;
    logic [9:0] amp_a, amp_b;

    always #5 clk = ~clk;

    midi_note_rx #(.CLKSPEED(CLKSPEED), .BAUD(BAUD), .CHANNEL(CHAN), .OMNI(1'b0)) dut_a (
        .clk(clk), .rst(rst), .midi_in(midi_in), .gate(gate_a), .note(note_a),
        .amp(amp_a), .retrig(retrig_a), .frame_err(fe_a)
    );

    midi_note_rx #(.CLKSPEED(CLKSPEED), .BAUD(BAUD), .CHANNEL(CHAN), .OMNI(1'b1)) dut_b (
        .clk(clk), .rst(rst), .midi_in(midi_in), .gate(gate_b), .note(note_b),
        .amp(amp_b), .retrig(retrig_b), .frame_err(fe_b)
    );

    typedef struct {
        bit gate;
        int note;
        int amp;
        bit retrig;
    } ev_t;

    ev_t qa[$];
    ev_t qb[$];
    int  checks = 0;
    int  passes = 0;
    int  exp_fe = 0;
    int  fe_cnt_a = 0;
    int  fe_cnt_b = 0;
    logic [17:0] last [2];

    // Reference model state per receiver (0: channel 5 only, 1: omni).
    // rs: 0 none, 1 note-off, 2 note-on, 3 ignore. key: -1 while awaiting a key.
    int m_rs [2];
    int m_key [2];
    bit m_gate [2];
    int m_note [2];
    int m_amp [2];

    task automatic check(input string name, input bit ok, input string detail);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_rs[d] = 0; m_key[d] = -1; m_gate[d] = 0; m_note[d] = 0; m_amp[d] = 0;
        end
        qa.delete();
        qb.delete();
    endtask

    task automatic push_ev(input int d, input ev_t e);
        if (d == 0) qa.push_back(e);
        else qb.push_back(e);
    endtask

    task automatic model_byte(input int b);
        for (int d = 0; d < 2; d++) begin
            bit chan_ok;
            int k;
            ev_t e;
            chan_ok = (d == 1) || (b % 16 == CHAN);
            if (b >= 'hF8) begin
                continue;
            end else if (b >= 'hF0) begin
                m_rs[d] = 0; m_key[d] = -1;
            end else if (b >= 'h80) begin
                m_key[d] = -1;
                if (chan_ok && b / 16 == 9) m_rs[d] = 2;
                else if (chan_ok && b / 16 == 8) m_rs[d] = 1;
                else m_rs[d] = 3;
            end else if (m_rs[d] == 1 || m_rs[d] == 2) begin
                if (m_key[d] < 0) begin
                    m_key[d] = b;
                end else begin
                    k = m_key[d];
                    m_key[d] = -1;
                    if (m_rs[d] == 2 && b != 0) begin
                        m_gate[d] = 1; m_note[d] = k; m_amp[d] = b * 8 + b / 16;
                        e.gate = 1; e.note = k; e.amp = m_amp[d]; e.retrig = 1;
                        push_ev(d, e);
                    end else if (m_gate[d] && k == m_note[d]) begin
                        m_gate[d] = 0; m_amp[d] = 0;
                        e.gate = 0; e.note = m_note[d]; e.amp = 0; e.retrig = 0;
                        push_ev(d, e);
                    end
                end
            end
        end
    endtask

    task automatic mon(input int d, input logic g, input logic [6:0] n, input logic [9:0] a, input logic r);
        logic [17:0] cur;
        ev_t e;
        int qsz;
        cur = {g, n, a};
        if (r || cur != last[d]) begin
            qsz = (d == 0) ? qa.size() : qb.size();
            if (qsz == 0) begin
                check($sformatf("unexpected_event_dut%0d", d), 1'b0,
                      $sformatf("got gate=%0d note=%0d amp=%0d retrig=%0d, required no output change", g, n, a, r));
            end else begin
                e = (d == 0) ? qa.pop_front() : qb.pop_front();
                check($sformatf("event_dut%0d", d),
                      g == e.gate && n == e.note && a == e.amp && r == e.retrig,
                      $sformatf("got gate=%0d note=%0d amp=%0d retrig=%0d, required gate=%0d note=%0d amp=%0d retrig=%0d",
                                g, n, a, r, e.gate, e.note, e.amp, e.retrig));
            end
        end
        last[d] = cur;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            last[0] = '0;
            last[1] = '0;
        end else begin
            mon(0, gate_a, note_a, amp_a, retrig_a);
            mon(1, gate_b, note_b, amp_b, retrig_b);
            if (fe_a) fe_cnt_a++;
            if (fe_b) fe_cnt_b++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap);
        midi_in = 1'b0;
        repeat (DIV) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            midi_in = b[i];
            repeat (DIV) @(posedge clk);
        end
        // Expectations are queued before the stop bit is sampled.
        if (stop_ok) model_byte(int'(b));
        else exp_fe++;
        midi_in = stop_ok;
        repeat (DIV) @(posedge clk);
        midi_in = 1'b1;
        repeat (gap) @(posedge clk);
        check("latency", qa.size() == 0 && qb.size() == 0,
              $sformatf("byte %02h: got %0d/%0d pending events, required 0/0", b, qa.size(), qb.size()));
    endtask

    task automatic send3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0, 1'b1, DIV);
        send_byte(b1, 1'b1, DIV);
        send_byte(b2, 1'b1, DIV);
    endtask

    task automatic check_zero(input string name);
        check(name, gate_a == 0 && note_a == 0 && amp_a == 0 && retrig_a == 0 && fe_a == 0,
              $sformatf("dut_a got gate=%0d note=%0d amp=%0d retrig=%0d fe=%0d, required all 0",
                        gate_a, note_a, amp_a, retrig_a, fe_a));
        check(name, gate_b == 0 && note_b == 0 && amp_b == 0 && retrig_b == 0 && fe_b == 0,
              $sformatf("dut_b got gate=%0d note=%0d amp=%0d retrig=%0d fe=%0d, required all 0",
                        gate_b, note_b, amp_b, retrig_b, fe_b));
    endtask

    initial begin
        logic [7:0] st, key, vel;
        int r;
        model_reset();
        repeat (4) @(posedge clk);
        #1 check_zero("reset_state");
        #2 rst = 1'b0;
        repeat (3 * DIV) @(posedge clk);

        // Basic note-on, running status, non-matching and matching note-off.
        send3(8'h95, 8'h3C, 8'h7F);
        send_byte(8'h40, 1'b1, DIV);
        send_byte(8'h40, 1'b1, DIV);
        send3(8'h85, 8'h3C, 8'h00);
        send_byte(8'h40, 1'b1, DIV);
        send_byte(8'h00, 1'b1, DIV);

        // Foreign channel: only the omni receiver responds.
        send3(8'h91, 8'h3C, 8'h64);

        // Realtime byte inside a message, then a system byte breaking one.
        send_byte(8'h95, 1'b1, DIV);
        send_byte(8'h3C, 1'b1, DIV);
        send_byte(8'hF8, 1'b1, DIV);
        send_byte(8'h50, 1'b1, DIV);
        send3(8'hF0, 8'h3C, 8'h50);

        // Short glitch while a key is pending, then a frame error, then recovery.
        send_byte(8'h95, 1'b1, DIV);
        send_byte(8'h22, 1'b1, DIV);
        midi_in = 1'b0;
        repeat (DIV * 3 / 10) @(posedge clk);
        midi_in = 1'b1;
        repeat (3 * DIV) @(posedge clk);
        check("glitch", fe_cnt_a == exp_fe && fe_cnt_b == exp_fe,
              $sformatf("got frame errors %0d/%0d, required %0d", fe_cnt_a, fe_cnt_b, exp_fe));
        send_byte(8'h7F, 1'b0, 2 * DIV);
        check("frame_err", fe_cnt_a == exp_fe && fe_cnt_b == exp_fe,
              $sformatf("got frame errors %0d/%0d, required %0d", fe_cnt_a, fe_cnt_b, exp_fe));
        send3(8'h95, 8'h22, 8'h33);

        // Reset in the middle of a velocity byte while the voice is gated.
        send3(8'h95, 8'h40, 8'h7F);
        send_byte(8'h41, 1'b1, DIV);
        midi_in = 1'b0;
        repeat (DIV) @(posedge clk);
        midi_in = 1'b1;
        repeat (2 * DIV + 3) @(posedge clk);
        #2 rst = 1'b1;
        #1 check_zero("async_reset");
        model_reset();
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (5 * DIV - 6) @(posedge clk);
        midi_in = 1'b0;
        repeat (DIV) @(posedge clk);
        midi_in = 1'b1;
        repeat (12 * DIV) @(posedge clk);
        check("after_reset", qa.size() == 0 && qb.size() == 0 && gate_a == 0 && gate_b == 0,
              $sformatf("got gate=%0d/%0d, required 0/0", gate_a, gate_b));
        send3(8'h95, 8'h30, 8'h7F);

        // Randomized message stream.
        for (int m = 0; m < 80; m++) begin
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                if ($urandom_range(0, 9) < 7) begin
                    st = ($urandom_range(0, 1) != 0) ? 8'h90 : 8'h80;
                    st[3:0] = ($urandom_range(0, 9) < 7) ? 4'(CHAN) : 4'($urandom_range(0, 15));
                    send_byte(st, 1'b1, $urandom_range(0, 20));
                end
                key = 8'(60 + $urandom_range(0, 3));
                send_byte(key, 1'b1, $urandom_range(0, 20));
                if ($urandom_range(0, 7) == 0) send_byte(8'(8'hF8 + $urandom_range(0, 7)), 1'b1, 0);
                vel = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 127));
                send_byte(vel, 1'b1, $urandom_range(0, 20));
            end else if (r == 6) begin
                send_byte(8'(8'hF8 + $urandom_range(0, 7)), 1'b1, $urandom_range(0, 20));
            end else if (r == 7) begin
                send_byte(8'(8'hF0 + $urandom_range(0, 7)), 1'b1, $urandom_range(0, 20));
            end else if (r == 8) begin
                send_byte(8'($urandom_range(8'hA0, 8'hEF)), 1'b1, $urandom_range(0, 20));
            end else begin
                send_byte(8'($urandom_range(0, 127)), 1'b1, $urandom_range(0, 20));
            end
        end

        repeat (4 * DIV) @(posedge clk);
        check("final_queue", qa.size() == 0 && qb.size() == 0,
              $sformatf("got %0d/%0d pending events, required 0/0", qa.size(), qb.size()));
        check("final_frame_err", fe_cnt_a == exp_fe && fe_cnt_b == exp_fe,
              $sformatf("got frame error cycles %0d/%0d, required %0d", fe_cnt_a, fe_cnt_b, exp_fe));
        check("final_state_a", gate_a == m_gate[0] && amp_a == m_amp[0] && note_a == m_note[0],
              $sformatf("got gate=%0d note=%0d amp=%0d, required gate=%0d note=%0d amp=%0d",
                        gate_a, note_a, amp_a, m_gate[0], m_note[0], m_amp[0]));
        check("final_state_b", gate_b == m_gate[1] && amp_b == m_amp[1] && note_b == m_note[1],
              $sformatf("got gate=%0d note=%0d amp=%0d, required gate=%0d note=%0d amp=%0d",
                        gate_b, note_b, amp_b, m_gate[1], m_note[1], m_amp[1]));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
